// File: rtl/cnn_layer_sequencer.sv
// Inference-pass sequencer: walks conv windows, then FC class/feature pairs, with credit-limited conv requests.
// Optional build macro SEQ_PERF_CNT_EN adds stall_cyc / pass_cyc performance counters.
module cnn_layer_sequencer #(
  parameter int IMG     = 28,
  parameter int K       = 5,
  parameter int NF      = 8,
  parameter int NCLS    = 10,
  parameter int FC_LEN  = 1152,
  parameter int MAX_OUT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        conv_valid,
  input  logic        conv_ready,
  output logic [2:0]  conv_filt,
  output logic [4:0]  conv_row,
  output logic [4:0]  conv_col,
  output logic        conv_last,
  input  logic        conv_resp,
  output logic        fc_valid,
  input  logic        fc_ready,
  output logic [3:0]  fc_class,
  output logic [10:0] fc_idx,
  output logic        fc_last,
  input  logic        fc_resp
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0] stall_cyc,
  output logic [31:0] pass_cyc
`endif
);

  localparam logic [4:0]  WIN_MAX  = 5'(IMG - K);
  localparam logic [2:0]  FILT_MAX = 3'(NF - 1);
  localparam logic [3:0]  CLS_MAX  = 4'(NCLS - 1);
  localparam logic [3:0]  CLS_NUM  = 4'(NCLS);
  localparam logic [10:0] IDX_MAX  = 11'(FC_LEN - 1);
  localparam logic [2:0]  OUT_MAX  = 3'(MAX_OUT);

  typedef enum logic [2:0] {IDLE, CONV, CONV_DRAIN, FC, FC_DRAIN, DONE} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  filt_reg, filt_next;
  logic [4:0]  row_reg, row_next;
  logic [4:0]  col_reg, col_next;
  logic [3:0]  cls_reg, cls_next;
  logic [10:0] idx_reg, idx_next;
  logic [2:0]  out_reg, out_next;
  logic [3:0]  resp_cnt_reg, resp_cnt_next;
  logic [3:0]  issued_reg, issued_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;
  logic        conv_valid_reg, conv_valid_next;
  logic        conv_last_reg, conv_last_next;
  logic        fc_valid_reg, fc_valid_next;
  logic        fc_last_reg, fc_last_next;
  logic        conv_acc, fc_acc, conv_resp_ok, fc_resp_ok;

  always_comb begin
    conv_acc      = conv_valid_reg & conv_ready;
    fc_acc        = fc_valid_reg & fc_ready;
    conv_resp_ok  = conv_resp && (out_reg != 3'd0);
    // a class response is only legal once that class's last feature was accepted
    fc_resp_ok    = fc_resp && (resp_cnt_reg < issued_reg);

    state_next    = state_reg;
    filt_next     = filt_reg;
    row_next      = row_reg;
    col_next      = col_reg;
    cls_next      = cls_reg;
    idx_next      = idx_reg;
    issued_next   = issued_reg;
    resp_cnt_next = resp_cnt_reg;
    out_next      = out_reg;
    err_next      = err_reg | (conv_resp & ~conv_resp_ok) | (fc_resp & ~fc_resp_ok);

    if (conv_acc && !conv_resp_ok)
      out_next = out_reg + 3'd1;
    else if (!conv_acc && conv_resp_ok)
      out_next = out_reg - 3'd1;
    if (fc_resp_ok)
      resp_cnt_next = resp_cnt_reg + 4'd1;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next    = CONV;
          filt_next     = 3'd0;
          row_next      = 5'd0;
          col_next      = 5'd0;
          cls_next      = 4'd0;
          idx_next      = 11'd0;
          issued_next   = 4'd0;
          resp_cnt_next = 4'd0;
          out_next      = 3'd0;
          err_next      = 1'b0;
        end
      end
      CONV: begin
        if (conv_acc) begin
          if (col_reg == WIN_MAX) begin
            col_next = 5'd0;
            if (row_reg == WIN_MAX) begin
              row_next  = 5'd0;
              filt_next = (filt_reg == FILT_MAX) ? 3'd0 : filt_reg + 3'd1;
            end else begin
              row_next = row_reg + 5'd1;
            end
          end else begin
            col_next = col_reg + 5'd1;
          end
          if (conv_last_reg)
            state_next = CONV_DRAIN;
        end
      end
      CONV_DRAIN: begin
        if (out_next == 3'd0)
          state_next = FC;
      end
      FC: begin
        if (fc_acc) begin
          if (idx_reg == IDX_MAX) begin
            idx_next    = 11'd0;
            cls_next    = (cls_reg == CLS_MAX) ? 4'd0 : cls_reg + 4'd1;
            issued_next = issued_reg + 4'd1;
            if (cls_reg == CLS_MAX)
              state_next = FC_DRAIN;
          end else begin
            idx_next = idx_reg + 11'd1;
          end
        end
      end
      FC_DRAIN: begin
        if (resp_cnt_next == CLS_NUM)
          state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // outputs are registered copies of what the next state will present
    busy_next       = (state_next != IDLE);
    done_next       = (state_next == DONE);
    conv_valid_next = (state_next == CONV) && (out_next < OUT_MAX);
    conv_last_next  = (state_next == CONV) && (filt_next == FILT_MAX) &&
                      (row_next == WIN_MAX) && (col_next == WIN_MAX);
    fc_valid_next   = (state_next == FC);
    fc_last_next    = (state_next == FC) && (idx_next == IDX_MAX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      filt_reg       <= 3'd0;
      row_reg        <= 5'd0;
      col_reg        <= 5'd0;
      cls_reg        <= 4'd0;
      idx_reg        <= 11'd0;
      out_reg        <= 3'd0;
      resp_cnt_reg   <= 4'd0;
      issued_reg     <= 4'd0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      conv_valid_reg <= 1'b0;
      conv_last_reg  <= 1'b0;
      fc_valid_reg   <= 1'b0;
      fc_last_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      filt_reg       <= filt_next;
      row_reg        <= row_next;
      col_reg        <= col_next;
      cls_reg        <= cls_next;
      idx_reg        <= idx_next;
      out_reg        <= out_next;
      resp_cnt_reg   <= resp_cnt_next;
      issued_reg     <= issued_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      err_reg        <= err_next;
      conv_valid_reg <= conv_valid_next;
      conv_last_reg  <= conv_last_next;
      fc_valid_reg   <= fc_valid_next;
      fc_last_reg    <= fc_last_next;
    end
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign err        = err_reg;
  assign conv_valid = conv_valid_reg;
  assign conv_filt  = filt_reg;
  assign conv_row   = row_reg;
  assign conv_col   = col_reg;
  assign conv_last  = conv_last_reg;
  assign fc_valid   = fc_valid_reg;
  assign fc_class   = cls_reg;
  assign fc_idx     = idx_reg;
  assign fc_last    = fc_last_reg;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] stall_reg, stall_next;
  logic [31:0] pass_reg, pass_next;
  logic        stalled;

  always_comb begin
    // throttle: in CONV but holding valid low because the credit limit is reached
    stalled    = (conv_valid_reg & ~conv_ready) | (fc_valid_reg & ~fc_ready) |
                 ((state_reg == CONV) && (out_reg >= OUT_MAX));
    stall_next = stall_reg;
    pass_next  = pass_reg;
    if (state_reg == IDLE) begin
      if (start) begin
        stall_next = 32'd0;
        pass_next  = 32'd0;
      end
    end else begin
      if (stalled && (stall_reg != 32'hFFFF_FFFF))
        stall_next = stall_reg + 32'd1;
      if (pass_reg != 32'hFFFF_FFFF)
        pass_next = pass_reg + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_reg <= 32'd0;
      pass_reg  <= 32'd0;
    end else begin
      stall_reg <= stall_next;
      pass_reg  <= pass_next;
    end
  end

  assign stall_cyc = stall_reg;
  assign pass_cyc  = pass_reg;
`endif

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Self-checking bench for cnn_layer_sequencer: transaction-count model checked every cycle plus directed scenarios.
module tb_cnn_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, err;
  logic        conv_valid, conv_last, fc_valid, fc_last;
  logic        conv_ready = 1'b0;
  logic        fc_ready = 1'b0;
  logic [2:0]  conv_filt;
  logic [4:0]  conv_row, conv_col;
  logic [3:0]  fc_class;
  logic [10:0] fc_idx;
  logic        conv_resp, fc_resp;
  logic        man_c = 1'b0, auto_c = 1'b0, auto_f = 1'b0;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] stall_cyc, pass_cyc;
`endif

  assign conv_resp = auto_c | man_c;
  assign fc_resp   = auto_f;

  cnn_layer_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .conv_valid(conv_valid), .conv_ready(conv_ready), .conv_filt(conv_filt),
    .conv_row(conv_row), .conv_col(conv_col), .conv_last(conv_last), .conv_resp(conv_resp),
    .fc_valid(fc_valid), .fc_ready(fc_ready), .fc_class(fc_class), .fc_idx(fc_idx),
    .fc_last(fc_last), .fc_resp(fc_resp)
`ifdef SEQ_PERF_CNT_EN
    , .stall_cyc(stall_cyc), .pass_cyc(pass_cyc)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: pass progress expressed as transaction counts
  int     m_conv_n = 0, m_fc_n = 0, m_out = 0, m_fcr = 0, m_issued = 0;
  bit     m_idle = 1'b1, m_err = 1'b0;
  longint m_stall = 0, m_pass = 0;
  int     cyc = 0, t_last = 0, t_fc = -1, done_cnt = 0;

  // Responder controls
  bit echo = 1'b0, slow_last = 1'b0;
  bit pend_c = 1'b0, pend_f = 1'b0;
  int cd = 0;

  always @(negedge clk) begin
    if (!rst) begin
      pend_c = 1'b0;
      pend_f = 1'b0;
      cd = 0;
    end else begin
      pend_c = echo && conv_valid && conv_ready && !(slow_last && conv_last);
      if (echo && conv_valid && conv_ready && slow_last && conv_last)
        cd = 20;
      pend_f = echo && fc_valid && fc_ready && fc_last;
    end
  end

  always @(posedge clk) begin
    #1;
    auto_c = pend_c;
    auto_f = pend_f;
    if (cd > 0) begin
      cd--;
      if (cd == 0)
        auto_c = 1'b1;
    end
  end

  // Compare against the model, then advance the model for the coming edge
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      m_conv_n = 0; m_fc_n = 0; m_out = 0; m_fcr = 0; m_issued = 0;
      m_idle = 1'b1; m_err = 1'b0; m_stall = 0; m_pass = 0;
      chk("rst_busy", busy, 0);
      chk("rst_conv_valid", conv_valid, 0);
      chk("rst_fc_valid", fc_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
    end else begin
      chk("busy", busy, !m_idle);
      chk("err", err, m_err);
      chk("conv_valid", conv_valid, !m_idle && m_conv_n < 4608 && m_out < 4);
      chk("fc_valid", fc_valid, !m_idle && m_conv_n == 4608 && m_out == 0 && m_fc_n < 11520);
      chk("done", done, !m_idle && m_fc_n == 11520 && m_fcr == 10);
      if (conv_valid) begin
        chk("conv_filt", conv_filt, m_conv_n / 576);
        chk("conv_row", conv_row, (m_conv_n / 24) % 24);
        chk("conv_col", conv_col, m_conv_n % 24);
        chk("conv_last", conv_last, m_conv_n == 4607);
        if (m_conv_n == 23) begin
          chk("pin23_row", conv_row, 0);
          chk("pin23_col", conv_col, 23);
        end
        if (m_conv_n == 24) begin
          chk("pin24_row", conv_row, 1);
          chk("pin24_col", conv_col, 0);
        end
        if (m_conv_n == 4607) begin
          chk("pinlast_filt", conv_filt, 7);
          chk("pinlast_row", conv_row, 23);
          chk("pinlast_col", conv_col, 23);
          chk("pinlast_last", conv_last, 1);
        end
      end
      if (fc_valid) begin
        chk("fc_class", fc_class, m_fc_n / 1152);
        chk("fc_idx", fc_idx, m_fc_n % 1152);
        chk("fc_last", fc_last, (m_fc_n % 1152) == 1151);
        if (m_fc_n == 1152) begin
          chk("pinfc_class", fc_class, 1);
          chk("pinfc_idx", fc_idx, 0);
        end
        if (m_fc_n == 11519) begin
          chk("pinfc_last_class", fc_class, 9);
          chk("pinfc_last_idx", fc_idx, 1151);
        end
        if (t_fc < 0)
          t_fc = cyc;
      end
`ifdef SEQ_PERF_CNT_EN
      chk("stall_cyc", stall_cyc, m_stall);
      chk("pass_cyc", pass_cyc, m_pass);
`endif
      if (done)
        done_cnt++;

      if (m_idle && start) begin
        m_idle = 1'b0; m_err = 1'b0;
        m_conv_n = 0; m_fc_n = 0; m_out = 0; m_fcr = 0; m_issued = 0;
        m_stall = 0; m_pass = 0; t_fc = -1;
      end else begin
        if (!m_idle) begin
          m_pass++;
          if ((conv_valid && !conv_ready) || (fc_valid && !fc_ready) ||
              (m_conv_n < 4608 && m_out >= 4))
            m_stall++;
        end
        if (conv_resp) begin
          if (m_out == 0) m_err = 1'b1;
          else m_out--;
        end
        if (fc_resp) begin
          if (m_fcr < m_issued) m_fcr++;
          else m_err = 1'b1;
        end
        if (!m_idle && conv_valid && conv_ready) begin
          m_conv_n++;
          m_out++;
          if (m_conv_n == 4608)
            t_last = cyc;
        end
        if (!m_idle && fc_valid && fc_ready) begin
          m_fc_n++;
          if (m_fc_n % 1152 == 0)
            m_issued++;
        end
        if (done)
          m_idle = 1'b1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic finish_bench();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    finish_bench();
  end

  initial begin
    // Reset values
    step(3);
    chk("reset_filt", conv_filt, 0);
    chk("reset_row", conv_row, 0);
    chk("reset_col", conv_col, 0);
    chk("reset_class", fc_class, 0);
    chk("reset_idx", fc_idx, 0);
    chk("reset_conv_last", conv_last, 0);
    chk("reset_fc_last", fc_last, 0);
    rst = 1'b1;
    step(2);
    $display("reset released");

    // Mid-CONV reset at request 100
    echo = 1'b1; conv_ready = 1'b1; fc_ready = 1'b1;
    start = 1'b1; step(1); start = 1'b0;
    chk("start_valid", conv_valid, 1);
    chk("start_col", conv_col, 0);
    for (int i = 0; i < 500 && m_conv_n < 100; i++) step(1);
    chk("req100_reached", m_conv_n, 100);
    chk("req100_row", conv_row, 4);
    chk("req100_col", conv_col, 4);
    rst = 1'b0; #1;
    chk("async_busy", busy, 0);
    chk("async_conv_valid", conv_valid, 0);
    chk("async_row", conv_row, 0);
    chk("async_col", conv_col, 0);
    step(3); rst = 1'b1; step(2);
    chk("no_done_after_abort", done_cnt, 0);
    $display("mid-conv reset done");

    // Full pass, ready high, responses echoed one cycle later
    start = 1'b1; step(1); start = 1'b0;
    for (int i = 0; i < 20000 && done_cnt < 1; i++) step(1);
    chk("passA_done", done_cnt, 1);
    step(5);
    chk("passA_single_done", done_cnt, 1);
    chk("passA_fc_gap", t_fc - t_last, 2);
    chk("passA_idle", busy, 0);
    $display("full pass done conv=%0d fc=%0d", m_conv_n, m_fc_n);

    // Credit throttle with responses withheld
    echo = 1'b0;
    start = 1'b1; step(1); start = 1'b0;
    step(10);
    chk("throttle_accepted", m_conv_n, 4);
    chk("throttle_valid", conv_valid, 0);
    man_c = 1'b1; step(1); man_c = 1'b0;
    chk("resume_valid", conv_valid, 1);
    chk("resume_col", conv_col, 4);
    step(2); rst = 1'b0; step(2); rst = 1'b1; step(2);
    $display("throttle test done");

    // conv_resp in IDLE sets err
    man_c = 1'b1; step(1); man_c = 1'b0; step(3);
    chk("err_idle", err, 1);

    // Toggled conv_ready with a slow final response
    echo = 1'b1; slow_last = 1'b1; conv_ready = 1'b0;
    start = 1'b1; step(1); start = 1'b0;
    chk("err_cleared", err, 0);
    for (int i = 0; i < 12000 && m_conv_n < 4608; i++) begin
      conv_ready = ~conv_ready;
      step(1);
    end
    conv_ready = 1'b1;
    chk("passC_conv_all", m_conv_n, 4608);
    for (int i = 0; i < 100 && t_fc < 0; i++) step(1);
    chk("slow_fc_gap", t_fc - t_last, 21);
    step(50);
    start = 1'b1; step(1); start = 1'b0;
    man_c = 1'b1; step(1); man_c = 1'b0; step(3);
    chk("err_fc", err, 1);
    chk("start_ignored_busy", busy, 1);
    for (int i = 0; i < 20000 && done_cnt < 2; i++) step(1);
    chk("passC_done", done_cnt, 2);
    step(2);
    chk("err_sticky", err, 1);
    $display("toggle pass done conv=%0d fc=%0d", m_conv_n, m_fc_n);

    // Next accepted start clears err
    start = 1'b1; step(1); start = 1'b0;
    chk("err_clear_start", err, 0);
    chk("passD_busy", busy, 1);
    step(20); rst = 1'b0; step(2); rst = 1'b1; step(2);
    $display("err clear test done");

    finish_bench();
  end

endmodule
